// File: rtl/data_mem.sv
// rtl/data_mem.sv - 256 x 16 single-port data memory, synchronous write, registered write-first read
module data_mem (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [7:0]  addr,
   input  logic [15:0] in,
   output logic [15:0] out
);

   logic [15:0] mem [0:255];

   // Array has no reset so preloaded contents survive; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (en && !reset) begin
         mem[addr] <= in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= 16'h0000;
      end else if (en) begin
         out <= in;
      end else begin
         out <= mem[addr];
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem
module tb_data_mem;

   logic        clk;
   logic        reset;
   logic        en;
   logic [7:0]  addr;
   logic [15:0] in;
   logic [15:0] out;

   int checks;
   int errors;

   logic [15:0] model [0:255];
   logic [15:0] expq [$];

   data_mem dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .addr  (addr),
      .in    (in),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle with reset released; expected read data comes from the bench model.
   task automatic cycle(input string tag, input logic e, input logic [7:0] a, input logic [15:0] d);
      logic [15:0] exp;
      @(negedge clk);
      en   = e;
      addr = a;
      in   = d;
      exp  = e ? d : model[a];
      if (e) model[a] = d;
      expq.push_back(exp);
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         check(tag, out, expq.pop_front());
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      dut.mem[a] = d;
      model[a]   = d;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      en     = 1'b0;
      addr   = 8'h00;
      in     = 16'h0000;

      for (int i = 0; i < 256; i++) preload(i[7:0], 16'h0000);
      preload(8'h00, 16'h1234);
      preload(8'h01, 16'h0BAD);
      preload(8'h02, 16'hBEEF);
      preload(8'h03, 16'h7001);
      preload(8'h04, 16'h8421);
      preload(8'h10, 16'hC3C3);

      @(posedge clk);
      #1;
      check("reset_out", out, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      // en=0 never modifies the array regardless of in
      for (int k = 0; k < 4; k++) cycle("hold_addr0", 1'b0, 8'h00, 16'hABCD);
      check("mem0_intact", dut.mem[0], 16'h1234);

      cycle("wr_15", 1'b1, 8'h15, 16'h1234);
      cycle("rd_15", 1'b0, 8'h15, 16'h0000);

      for (int a = 0; a < 5; a++)
         for (int k = 0; k < 3; k++) cycle("step_rd", 1'b0, a[7:0], 16'hABCD);
      for (int a = 0; a < 5; a++) check("step_mem", dut.mem[a], model[a]);

      cycle("wr_ff", 1'b1, 8'hFF, 16'hFFFF);
      cycle("wr_00", 1'b1, 8'h00, 16'h0001);
      cycle("rd_ff", 1'b0, 8'hFF, 16'h0000);
      cycle("rd_00", 1'b0, 8'h00, 16'h0000);

      cycle("b2b_1", 1'b1, 8'h20, 16'h1111);
      cycle("b2b_2", 1'b1, 8'h20, 16'h2222);
      cycle("b2b_rd", 1'b0, 8'h20, 16'h0000);

      for (int k = 0; k < 20; k++) begin
         logic [7:0]  ra;
         logic [15:0] rd;
         logic        re;
         ra = 8'($urandom_range(0, 255));
         rd = 16'($urandom);
         re = 1'($urandom_range(0, 1));
         cycle("rand", re, ra, rd);
      end

      cycle("pre_rst", 1'b0, 8'h15, 16'h0000);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async", out, 16'h0000);
      check("rst_mem15", dut.mem[8'h15], 16'h1234);

      // write attempted while reset is held must be dropped
      @(negedge clk);
      en   = 1'b1;
      addr = 8'h10;
      in   = 16'h5A5A;
      @(posedge clk);
      #1;
      check("rst_out_hold", out, 16'h0000);
      check("rst_wr_drop", dut.mem[8'h10], 16'hC3C3);
      reset = 1'b0;
      en    = 1'b0;
      addr  = 8'h15;

      cycle("post_rst_15", 1'b0, 8'h15, 16'h0000);
      cycle("post_rst_10", 1'b0, 8'h10, 16'h0000);
      check("mem0_final", dut.mem[0], model[0]);
      check("memff_final", dut.mem[8'hFF], 16'hFFFF);

      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover %0d entries expected 0", expq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem.md
# data_mem

Single-port 256 x 16-bit data memory for the DSP datapath. Supports synchronous writes and registered reads. The storage array can be preloaded from a binary file for program/data initialisation. It sits beside the core as the data store addressed by load/store instructions.

## Interface

Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- none; fixed geometry of 256 words x 16 bits, 8-bit address.

Ports:
- clk  input  1  system clock; all writes and read-register updates occur on its rising edge
- reset  input  1  asynchronous, active-high; clears the read-data register only
- en  input  1  write enable; 1 = write `in` to `mem[addr]` on the rising edge
- addr  input  8  word address, 0x00–0xFF
- in  input  16  write data
- out  output  16  registered read data

## Operation

- Storage:
  - Array named `mem`, 256 entries of 16 bits, indices 0..255.
  - Must be hierarchically accessible, so a bench can load it with `$readmemb` into `<inst>.mem` starting at index 0, and can display individual entries.
  - Entries not preloaded power up as 0.
- Write: on rising clk with en=1, `mem[addr] <= in`.
  - With en=0 the array is never modified, regardless of `in`.
- Read: on every rising clk, `out <= mem[addr]`.
- Read during write (en=1): write-first.
  - `out` takes `in` on the same edge that writes it.
  - `out` therefore always equals the post-edge content of `mem[addr]`.
- Reset:
  - While reset=1, `out` = 16'h0000 immediately (asynchronous).
  - The `mem` contents are NOT cleared; preloaded data survives reset.
  - Writes are suppressed while reset=1.
- Address has full 8-bit decode; all 256 locations are distinct and there is no aliasing.
- No out-of-range case exists and there are no error outputs.

## Timing

- Write latency:
  - The location is updated at the rising edge where en=1.
  - A read of that address at the next edge returns the new data.
- Read latency: 1 cycle. `addr` applied before edge N gives `mem[addr]` on `out` after edge N, held until the next edge.
- `out` is stable between edges and is unaffected by `addr`/`in` changes that occur between edges.
- Reset assertion:
  - Forces `out`=0 without waiting for clk.
  - On deassertion, `out` reloads from `mem[addr]` at the first rising edge.
- Reset asserted mid-write cycle: the write at that edge is dropped; the array is unchanged.
- Back-to-back writes to the same address on consecutive edges: the last write wins, and `out` follows each written value.

## Test plan

1. Preload `mem[0]`=16'h1234 via `$readmemb`; en=0, addr=0x00, in=16'hABCD; wait several cycles -> `out`=16'h1234 and `mem[0]` is still 16'h1234.
2. en=1, addr=0x15, in=16'h1234 for one edge, then en=0 -> `out`=16'h1234 after that edge; a later read of 0x15 returns 16'h1234.
3. Preload `mem[0..4]` with distinct values; en=0, in=16'hABCD, step addr 0x00→0x04 holding each for several cycles -> `out` matches each preloaded word one edge after the address changes, and no location changes.
4. Boundary: write 16'hFFFF to 0xFF and 16'h0001 to 0x00 -> reads return 16'hFFFF and 16'h0001, with no aliasing between them.
5. With `out`=16'h1234, assert reset between edges -> `out`=0 immediately. Deassert -> first edge restores 16'h1234; `mem` contents are intact.
6. Assert en=1 together with reset at addr 0x10, in=16'h5A5A -> after reset is released, a read of 0x10 returns its prior value, not 16'h5A5A.
